// File: rtl/multdiv_ctrl.sv
// Sequencer between the pipeline and the iterative multiplier/divider: one op in flight,
// start pulse, wait for RDY or timeout, tagged response. Option: MULTDIV_DIV0_SHORTCUT_EN.
module multdiv_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int TAG_W   = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic             req_op,
    input  logic [31:0]      req_operandA,
    input  logic [31:0]      req_operandB,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_ready,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic [31:0]      data_operandA,
    output logic [31:0]      data_operandB,
    input  logic [31:0]      data_result,
    input  logic             data_exception,
    input  logic             data_resultRDY,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_exception,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_op,
    output logic             busy
);
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 6) ? $clog2(TIMEOUT + 1) : 6;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept, div0, timeout;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    // cnt holds the number of WAIT cycles already completed, so the TIMEOUT-th
    // WAIT cycle is the last one in which RDY is still honoured.
    assign timeout   = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef MULTDIV_DIV0_SHORTCUT_EN
    assign div0 = req_op && (req_operandB == '0);
`else
    assign div0 = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = div0 ? DONE : START;
            START:   state_nxt = WAIT;
            WAIT:    if (data_resultRDY || timeout) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_MULT     <= 1'b0;
            ctrl_DIV      <= 1'b0;
            data_operandA <= '0;
            data_operandB <= '0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_exception <= 1'b0;
            rsp_tag       <= '0;
            rsp_op        <= 1'b0;
            cnt           <= '0;
        end else begin
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            if (accept) begin
                data_operandA <= req_operandA;
                data_operandB <= req_operandB;
                // rsp_op is live from acceptance since it steers the external result mux
                rsp_op        <= req_op;
                rsp_tag       <= req_tag;
                if (div0) begin
                    rsp_valid     <= 1'b1;
                    rsp_result    <= '0;
                    rsp_exception <= 1'b1;
                end else begin
                    ctrl_MULT <= !req_op;
                    ctrl_DIV  <= req_op;
                end
            end
            if (state == START)
                cnt <= '0;
            else if (state == WAIT && cnt != '1)
                cnt <= cnt + 1'b1;
            if (state == WAIT) begin
                if (data_resultRDY) begin
                    rsp_valid     <= 1'b1;
                    rsp_result    <= data_result;
                    rsp_exception <= data_exception;
                end else if (timeout) begin
                    rsp_valid     <= 1'b1;
                    rsp_result    <= '0;
                    rsp_exception <= 1'b1;
                end
            end
            if (state == DONE && rsp_ready)
                rsp_valid <= 1'b0;
        end
    end
endmodule
